// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: shared widths, grant encoding, request bundle and the
// word-alignment helper for the ROM32 port arbiter.
// Optional build macro: ROM_ARB_ROUND_ROBIN_EN (used by rom_arb_grant).
package rom_arb_pkg;

  // ROM32 byte-address width (word aligned) and word width
  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;

  // Which port, if any, owns the ROM this cycle
  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_IF,
    GNT_LS
  } grant_e;

  // One requester's view of the ROM: a request strobe plus its byte address
  typedef struct packed {
    logic              req;
    logic [ADDR_W-1:0] addr;
  } rom_req_t;

  // A ROM access must land on a 32-bit word boundary
  function automatic logic misaligned(input logic [ADDR_W-1:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/rom_port_arbiter_if.sv
// rom_port_arbiter_if: bundles the IF port, the LS port and the ROM32 side
// of the arbiter. The slave modport is the arbiter's view; the master
// modport is the view of the requesters and the ROM.
// Optional build macro: ROM_ARB_ROUND_ROBIN_EN (no effect on this file).
interface rom_port_arbiter_if;
  import rom_arb_pkg::*;

  // Instruction-fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              if_err;

  // Load/store constant-read port
  logic              ls_req;
  logic [ADDR_W-1:0] ls_addr;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;
  logic              ls_err;

  // Combinational ROM32
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  modport slave (
    input  if_req, if_addr, ls_req, ls_addr, rom_data,
    output if_gnt, if_rvalid, if_rdata, if_err,
    output ls_gnt, ls_rvalid, ls_rdata, ls_err,
    output rom_addr
  );

  modport master (
    output if_req, if_addr, ls_req, ls_addr, rom_data,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    input  ls_gnt, ls_rvalid, ls_rdata, ls_err,
    input  rom_addr
  );

endinterface

// File: rtl/rom_arb_grant.sv
// rom_arb_grant: picks at most one of IF/LS each cycle.
// Default build: IF has fixed priority, but an LS request that has been
// denied MAX_WAIT cycles in a row wins the next contention.
// With ROM_ARB_ROUND_ROBIN_EN defined: a one-bit last-grant pointer makes
// the two ports alternate whenever both are requesting.
module rom_arb_grant
  import rom_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   if_req,
  input  logic   ls_req,
  output grant_e grant
);

`ifdef ROM_ARB_ROUND_ROBIN_EN

  // High when LS got the most recent grant, so IF wins the first tie
  logic last_ls;

  // Remember who was served last; idle cycles leave the pointer alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_ls <= 1'b1;
    end else if (grant == GNT_IF) begin
      last_ls <= 1'b0;
    end else if (grant == GNT_LS) begin
      last_ls <= 1'b1;
    end
  end

  // Ties go to whoever was not served last; a lone requester always wins
  always_comb begin
    grant = GNT_NONE;
    if (!rst_n) begin
      grant = GNT_NONE;
    end else if (if_req && ls_req) begin
      grant = last_ls ? GNT_IF : GNT_LS;
    end else if (if_req) begin
      grant = GNT_IF;
    end else if (ls_req) begin
      grant = GNT_LS;
    end
  end

`else

  // MAX_WAIT of 0 still needs a one-bit counter that simply stays at 0
  localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] wait_cnt_next;

  // Consecutive-denial counter for a pending LS request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt_next;
    end
  end

  // IF first, unless LS is alone or has waited long enough
  always_comb begin
    grant = GNT_NONE;
    if (!rst_n) begin
      grant = GNT_NONE;
    end else if (ls_req && (!if_req || (wait_cnt == WAIT_LIMIT))) begin
      grant = GNT_LS;
    end else if (if_req) begin
      grant = GNT_IF;
    end
  end

  // Count denied LS cycles up to the limit; a grant or a dropped request clears it
  always_comb begin
    wait_cnt_next = '0;
    if (ls_req && (grant != GNT_LS)) begin
      wait_cnt_next = (wait_cnt == WAIT_LIMIT) ? wait_cnt : wait_cnt + 1'b1;
    end
  end

`endif

endmodule

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares the combinational ROM32 between instruction
// fetch (IF) and load-path constant reads (LS). The grant is decided in the
// same cycle, the ROM address is muxed from the winner, and the ROM word is
// registered back to that port one cycle later with an alignment error flag.
// Optional build macro: ROM_ARB_ROUND_ROBIN_EN (selects round-robin grant).
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rom_port_arbiter_if.slave     bus
);

  grant_e            grant;
  rom_req_t          sel;
  logic              sel_err;
  logic [DATA_W-1:0] sel_word;

  logic              if_rvalid_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic              if_err_q;
  logic              ls_rvalid_q;
  logic [DATA_W-1:0] ls_rdata_q;
  logic              ls_err_q;

  rom_arb_grant #(
    .MAX_WAIT (MAX_WAIT)
  ) u_grant (
    .clk    (clk),
    .rst_n  (rst_n),
    .if_req (bus.if_req),
    .ls_req (bus.ls_req),
    .grant  (grant)
  );

  // Route the winning port's request to the ROM; no winner means address 0
  always_comb begin
    sel = '0;
    case (grant)
      GNT_IF:  sel = '{req: 1'b1, addr: bus.if_addr};
      GNT_LS:  sel = '{req: 1'b1, addr: bus.ls_addr};
      default: sel = '0;
    endcase
  end

  // A misaligned access returns a zero word instead of ROM data
  always_comb begin
    sel_err  = misaligned(sel.addr);
    sel_word = sel_err ? '0 : bus.rom_data;
  end

  // Capture the ROM word for the granted port; rdata/err hold between responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      if_err_q    <= 1'b0;
      ls_rvalid_q <= 1'b0;
      ls_rdata_q  <= '0;
      ls_err_q    <= 1'b0;
    end else begin
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if (sel.req && (grant == GNT_IF)) begin
        if_rvalid_q <= 1'b1;
        if_rdata_q  <= sel_word;
        if_err_q    <= sel_err;
      end
      if (sel.req && (grant == GNT_LS)) begin
        ls_rvalid_q <= 1'b1;
        ls_rdata_q  <= sel_word;
        ls_err_q    <= sel_err;
      end
    end
  end

  assign bus.if_gnt    = (grant == GNT_IF);
  assign bus.ls_gnt    = (grant == GNT_LS);
  assign bus.rom_addr  = sel.addr;

  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_err    = if_err_q;
  assign bus.ls_rvalid = ls_rvalid_q;
  assign bus.ls_rdata  = ls_rdata_q;
  assign bus.ls_err    = ls_err_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter: directed bench for rom_port_arbiter with a small ROM32
// model, a reference grant model and a response scoreboard.
// Optional build macro: ROM_ARB_ROUND_ROBIN_EN (reference model follows it).
module tb_rom_port_arbiter;
  import rom_arb_pkg::*;

  localparam int MAX_WAIT = 4;

  typedef struct {
    grant_e            port;
    logic [DATA_W-1:0] data;
    logic              err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int failures = 0;

  exp_t sbq[$];

  int                wcnt;
  logic              last_ls;
  logic [DATA_W-1:0] m_if_rdata;
  logic [DATA_W-1:0] m_ls_rdata;
  grant_e            cur_g;
  logic              cur_lsr;

  always #5 clk = ~clk;

  rom_port_arbiter_if bus ();

  rom_port_arbiter #(
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ROM32 contents seen by the bench: first words fixed, the rest a tagged pattern
  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-3:0] idx;
    idx = a[ADDR_W-1:2];
    case (idx)
      9'd0:    return 32'h0000_0001;
      9'd1:    return 32'h0000_0200;
      9'd2:    return 32'h0000_0000;
      default: return 32'hC0DE_0000 | {23'd0, idx};
    endcase
  endfunction

  assign bus.rom_data = rom_word(bus.rom_addr);

  // Reference grant decision from the current requests and model state
  function automatic grant_e modelGrant(input logic ifr, input logic lsr);
`ifdef ROM_ARB_ROUND_ROBIN_EN
    if (ifr && lsr) return last_ls ? GNT_IF : GNT_LS;
    if (ifr) return GNT_IF;
    if (lsr) return GNT_LS;
    return GNT_NONE;
`else
    if (lsr && (!ifr || (wcnt == MAX_WAIT))) return GNT_LS;
    if (ifr) return GNT_IF;
    return GNT_NONE;
`endif
  endfunction

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkResetState(input string tag);
    check({tag, ".if_gnt"},    32'(bus.if_gnt),    32'd0);
    check({tag, ".ls_gnt"},    32'(bus.ls_gnt),    32'd0);
    check({tag, ".rom_addr"},  32'(bus.rom_addr),  32'd0);
    check({tag, ".if_rvalid"}, 32'(bus.if_rvalid), 32'd0);
    check({tag, ".ls_rvalid"}, 32'(bus.ls_rvalid), 32'd0);
    check({tag, ".if_rdata"},  bus.if_rdata,       32'd0);
    check({tag, ".ls_rdata"},  bus.ls_rdata,       32'd0);
    check({tag, ".if_err"},    32'(bus.if_err),    32'd0);
    check({tag, ".ls_err"},    32'(bus.ls_err),    32'd0);
  endtask

  // Drive one cycle of requests, check the combinational grant, queue the expected response
  task automatic applyStimulus(input logic ifr, input logic [ADDR_W-1:0] ifa,
                               input logic lsr, input logic [ADDR_W-1:0] lsa,
                               input string tag);
    exp_t              e;
    logic [ADDR_W-1:0] a;
    bus.if_req  = ifr;
    bus.if_addr = ifa;
    bus.ls_req  = lsr;
    bus.ls_addr = lsa;
    #1;
    cur_g   = modelGrant(ifr, lsr);
    cur_lsr = lsr;
    a = (cur_g == GNT_IF) ? ifa : (cur_g == GNT_LS) ? lsa : '0;
    check({tag, ".if_gnt"},   32'(bus.if_gnt),   32'(cur_g == GNT_IF));
    check({tag, ".ls_gnt"},   32'(bus.ls_gnt),   32'(cur_g == GNT_LS));
    check({tag, ".rom_addr"}, 32'(bus.rom_addr), 32'(a));
    e.port = cur_g;
    e.err  = (cur_g != GNT_NONE) && (a[1:0] != 2'b00);
    e.data = (cur_g == GNT_NONE || e.err) ? '0 : rom_word(a);
    sbq.push_back(e);
  endtask

  // Advance one edge, update the reference state, compare the registered response
  task automatic checkOutput(input string tag);
    exp_t e;
    @(posedge clk);
`ifdef ROM_ARB_ROUND_ROBIN_EN
    if (cur_g == GNT_IF) last_ls = 1'b0;
    else if (cur_g == GNT_LS) last_ls = 1'b1;
`else
    if (cur_lsr && (cur_g != GNT_LS)) wcnt = (wcnt == MAX_WAIT) ? wcnt : wcnt + 1;
    else wcnt = 0;
`endif
    #1;
    if (sbq.size() == 0) begin
      checks++;
      failures++;
      $error("[TB] FAIL %s.scoreboard observed=empty expected=entry", tag);
    end else begin
      e = sbq.pop_front();
      if (e.port == GNT_IF) m_if_rdata = e.data;
      if (e.port == GNT_LS) m_ls_rdata = e.data;
      check({tag, ".if_rvalid"}, 32'(bus.if_rvalid), 32'(e.port == GNT_IF));
      check({tag, ".ls_rvalid"}, 32'(bus.ls_rvalid), 32'(e.port == GNT_LS));
      check({tag, ".if_rdata"},  bus.if_rdata,       m_if_rdata);
      check({tag, ".ls_rdata"},  bus.ls_rdata,       m_ls_rdata);
      if (e.port == GNT_IF) check({tag, ".if_err"}, 32'(bus.if_err), 32'(e.err));
      if (e.port == GNT_LS) check({tag, ".ls_err"}, 32'(bus.ls_err), 32'(e.err));
    end
  endtask

  task automatic step(input logic ifr, input logic [ADDR_W-1:0] ifa,
                      input logic lsr, input logic [ADDR_W-1:0] lsa,
                      input string tag);
    applyStimulus(ifr, ifa, lsr, lsa, tag);
    checkOutput(tag);
  endtask

  task automatic resetModel();
    sbq.delete();
    wcnt       = 0;
    last_ls    = 1'b1;
    m_if_rdata = '0;
    m_ls_rdata = '0;
    cur_g      = GNT_NONE;
    cur_lsr    = 1'b0;
  endtask

  initial begin
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.ls_req  = 1'b0;
    bus.ls_addr = '0;
    resetModel();

    // Reset: requests present but grants and all outputs held at 0
    repeat (2) @(posedge clk);
    #1;
    bus.if_req  = 1'b1;
    bus.if_addr = 11'h004;
    bus.ls_req  = 1'b1;
    bus.ls_addr = 11'h008;
    #1;
    checkResetState("reset");
    bus.if_req = 1'b0;
    bus.ls_req = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    $display("[TB] reset released");

    step(1'b1, 11'h004, 1'b0, 11'h000, "if_only");
    step(1'b0, 11'h000, 1'b0, 11'h000, "idle0");
    step(1'b0, 11'h000, 1'b1, 11'h006, "ls_misalign");
    step(1'b1, 11'h000, 1'b0, 11'h000, "b2b_0");
    step(1'b1, 11'h004, 1'b0, 11'h000, "b2b_1");
    step(1'b1, 11'h008, 1'b0, 11'h000, "b2b_2");
    step(1'b0, 11'h000, 1'b0, 11'h000, "idle1");

    // Both ports held: IF x4 then LS (default) or strict alternation (round robin)
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 11'h00C, 1'b1, 11'h000, $sformatf("contend%0d", i));
    end
    step(1'b0, 11'h000, 1'b0, 11'h000, "idle2");

    // An LS request dropped before its grant must restart its wait from zero
    step(1'b1, 11'h010, 1'b1, 11'h004, "drop_a");
    step(1'b1, 11'h010, 1'b1, 11'h004, "drop_b");
    step(1'b1, 11'h010, 1'b0, 11'h000, "drop_gap");
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 11'h010, 1'b1, 11'h004, $sformatf("rewait%0d", i));
    end
    step(1'b0, 11'h000, 1'b1, 11'h014, "ls_only");
    step(1'b0, 11'h000, 1'b0, 11'h000, "idle3");

    // Reset mid-operation: the granted IF read must never come back
    applyStimulus(1'b1, 11'h004, 1'b0, 11'h000, "pre_reset");
    #1;
    rst_n = 1'b0;
    #1;
    checkResetState("mid_reset");
    resetModel();
    bus.if_req = 1'b0;
    @(posedge clk);
    #1;
    checkResetState("reset_hold");
    rst_n = 1'b1;
    step(1'b0, 11'h000, 1'b0, 11'h000, "post_reset0");
    step(1'b0, 11'h000, 1'b0, 11'h000, "post_reset1");
    step(1'b1, 11'h008, 1'b1, 11'h000, "after_reset");
    step(1'b0, 11'h000, 1'b0, 11'h000, "idle4");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
